capsense_debounce: RTL



---
 rtl/capsense_pkg.sv | 24 ++
 rtl/capsense_debounce_if.sv | 28 ++
 rtl/capsense_evt_fifo.sv | 60 ++++++
 rtl/capsense_debounce.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/capsense_pkg.sv
// Shared event encodings and types for the CapSense debounce block.
// Pure declarations: no logic, no latency, no flow control.
package capsense_pkg;

  localparam int EVT_TYPE_W    = 2;
  localparam int EVT_IDX_MAX_W = 8;

  typedef enum logic [EVT_TYPE_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_type_e;

  // Generic event record; blocks narrow idx to their own button count.
  typedef struct packed {
    logic [EVT_IDX_MAX_W-1:0] idx;
    evt_type_e                typ;
  } evt_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/capsense_debounce_if.sv
// Event stream from the debounce block: FWFT head plus valid/ready.
// The master holds idx/type stable while valid is high and ready is low.
interface capsense_debounce_if
  import capsense_pkg::*;
#(
  parameter int IDX_W = 2
);

  logic                  evt_valid_o;
  logic                  evt_ready_i;
  logic [IDX_W-1:0]      evt_idx_o;
  logic [EVT_TYPE_W-1:0] evt_type_o;

  modport master (
    output evt_valid_o,
    output evt_idx_o,
    output evt_type_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_idx_o,
    input  evt_type_o,
    output evt_ready_i
  );

endinterface

// File: rtl/capsense_evt_fifo.sv
// First-word-fall-through FIFO; head visible the cycle after the first push.
// Pop is ignored when empty; push is refused when full unless a pop frees a slot.
module capsense_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/capsense_debounce.sv
// Per-button saturating-integrator debounce with PRESS/RELEASE/LONG events.
// buttons_o lags a strobe by one edge; events leave through a FWFT queue, lost events set overflow_o.
module capsense_debounce
  import capsense_pkg::*;
#(
  parameter int N            = 4,
  parameter int INTEG        = 3,
  parameter int LONG_SAMPLES = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sample_valid_i,
  input  logic [N-1:0]        sampled_i,
  input  logic                clr_i,
  output logic [N-1:0]        buttons_o,
  output logic                overflow_o,
  capsense_debounce_if.master evt
);

  localparam int IDX_W = idx_width(N);
  localparam int INT_W = $clog2(INTEG + 1);
  localparam int LC_W  = $clog2(LONG_SAMPLES + 1);
  localparam int FW    = IDX_W + EVT_TYPE_W;

  localparam logic [INT_W-1:0] INT_MAX = INT_W'(INTEG);
  localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LONG_SAMPLES);

  logic [INT_W-1:0] integ_q [N];
  logic [INT_W-1:0] integ_d [N];
  logic [LC_W-1:0]  long_q  [N];
  logic [LC_W-1:0]  long_d  [N];
  logic [N-1:0]     state_q;
  logic [N-1:0]     state_d;
  logic [N-1:0]     set_press;
  logic [N-1:0]     set_rel;
  logic [N-1:0]     set_long;

  logic [N-1:0]     pend_press_q;
  logic [N-1:0]     pend_rel_q;
  logic [N-1:0]     pend_long_q;
  logic [N-1:0]     clr_press;
  logic [N-1:0]     clr_rel;
  logic [N-1:0]     clr_long;
  logic             collision;

  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  evt_type_e        sel_typ;

  logic [FW-1:0]    pop_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;
  logic             ovf_q;

  // Only the fully saturated ends of the integrator flip state.
  always_comb begin
    state_d   = state_q;
    set_press = '0;
    set_rel   = '0;
    set_long  = '0;
    for (int i = 0; i < N; i++) begin
      integ_d[i] = integ_q[i];
      long_d[i]  = long_q[i];
      if (sample_valid_i) begin
        if (sampled_i[i]) begin
          integ_d[i] = (integ_q[i] == INT_MAX) ? INT_MAX : integ_q[i] + INT_W'(1);
        end else begin
          integ_d[i] = (integ_q[i] == '0) ? '0 : integ_q[i] - INT_W'(1);
        end
        if (integ_d[i] == INT_MAX && !state_q[i]) begin
          state_d[i]   = 1'b1;
          set_press[i] = 1'b1;
          long_d[i]    = '0;
        end else if (integ_d[i] == '0 && state_q[i]) begin
          state_d[i] = 1'b0;
          set_rel[i] = 1'b1;
          long_d[i]  = '0;
        end else if (state_q[i] && long_q[i] != LC_MAX) begin
          long_d[i] = long_q[i] + LC_W'(1);
          if (long_d[i] == LC_MAX) begin
            set_long[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      integ_q <= '{default: '0};
      long_q  <= '{default: '0};
      state_q <= '0;
    end else if (sample_valid_i) begin
      integ_q <= integ_d;
      long_q  <= long_d;
      state_q <= state_d;
    end
  end

  // Lowest button wins; within a button PRESS, then RELEASE, then LONG.
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    sel_typ   = EVT_PRESS;
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    for (int i = 0; i < N; i++) begin
      if (!sel_vld) begin
        if (pend_press_q[i]) begin
          sel_vld      = 1'b1;
          sel_idx      = IDX_W'(i);
          sel_typ      = EVT_PRESS;
          clr_press[i] = 1'b1;
        end else if (pend_rel_q[i]) begin
          sel_vld    = 1'b1;
          sel_idx    = IDX_W'(i);
          sel_typ    = EVT_RELEASE;
          clr_rel[i] = 1'b1;
        end else if (pend_long_q[i]) begin
          sel_vld     = 1'b1;
          sel_idx     = IDX_W'(i);
          sel_typ     = EVT_LONG;
          clr_long[i] = 1'b1;
        end
      end
    end
  end

  // A bit being drained this cycle can be re-set without losing anything.
  assign collision = |((pend_press_q & ~clr_press & set_press) |
                       (pend_rel_q   & ~clr_rel   & set_rel)   |
                       (pend_long_q  & ~clr_long  & set_long));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      pend_long_q  <= '0;
    end else begin
      pend_press_q <= (pend_press_q & ~clr_press) | set_press;
      pend_rel_q   <= (pend_rel_q   & ~clr_rel)   | set_rel;
      pend_long_q  <= (pend_long_q  & ~clr_long)  | set_long;
    end
  end

  assign fifo_pop = evt.evt_ready_i & ~fifo_empty;
  assign drop     = sel_vld & fifo_full & ~fifo_pop;

  capsense_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (sel_vld),
    .push_dat ({sel_idx, sel_typ}),
    .pop      (fifo_pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A fresh loss outranks a clear arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (collision || drop) begin
      ovf_q <= 1'b1;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign buttons_o       = state_q;
  assign overflow_o      = ovf_q;
  assign evt.evt_valid_o = ~fifo_empty;
  assign evt.evt_idx_o   = pop_dat[FW-1:EVT_TYPE_W];
  assign evt.evt_type_o  = pop_dat[EVT_TYPE_W-1:0];

endmodule
